// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: bus-mapped UART receive controller with baud programming,
// receive FIFO, sticky overrun status and level interrupt.
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [13:0] BAUD_RESET = 14'd9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic [13:0] baudrate_reg,
    output logic        rx_reset,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          rx_en, irq_en, overrun, rx_done_q;
    logic [1:0]    baud_hold;
    logic          rd, wr, sel_data, sel_stat, sel_ctrl, sel_baud;
    logic          full, not_empty, pop, push, accept, flush, baud_wr;
    logic [31:0]   rdata_next;
    logic          unused;

    assign rd        = bus_sel & ~bus_we;
    assign wr        = bus_sel & bus_we;
    assign sel_data  = bus_addr == 4'h0;
    assign sel_stat  = bus_addr == 4'h4;
    assign sel_ctrl  = bus_addr == 4'h8;
    assign sel_baud  = bus_addr == 4'hC;
    assign full      = count == CW'(FIFO_DEPTH);
    assign not_empty = count != '0;
    assign pop       = rd & sel_data & not_empty;
    assign push      = rx_done & ~rx_done_q & rx_en & ~rx_reset;
    assign flush     = wr & sel_ctrl & bus_wdata[2];
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign accept    = push & (~full | pop) & ~flush;
    // zero would make the receiver divide by zero
    assign baud_wr   = wr & sel_baud & (bus_wdata[13:0] != 14'd0);
    assign rx_reset  = ~rx_en | (baud_hold != 2'd0);
    assign unused    = ^bus_wdata[31:14];

    always_comb begin
        rdata_next = sel_data ? (not_empty ? {23'd0, 1'b1, mem[rd_ptr]} : 32'd0)
                   : sel_stat ? 32'({count, 1'b0, overrun, full, not_empty})
                   : sel_ctrl ? {30'd0, irq_en, rx_en}
                   : sel_baud ? {18'd0, baudrate_reg}
                   : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata    <= '0;
            bus_ready    <= 1'b0;
            baudrate_reg <= BAUD_RESET;
            irq          <= 1'b0;
            rx_en        <= 1'b0;
            irq_en       <= 1'b0;
            overrun      <= 1'b0;
            rx_done_q    <= 1'b0;
            baud_hold    <= 2'd0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            bus_ready <= bus_sel;
            bus_rdata <= rd ? rdata_next : 32'd0;
            irq       <= irq_en & not_empty;
            rx_done_q <= rx_reset ? 1'b0 : rx_done;
            baud_hold <= baud_wr ? 2'd2 : baud_hold - {1'b0, |baud_hold};
            overrun   <= (push & full & ~pop & ~flush) | (overrun & ~(wr & sel_stat & bus_wdata[2]));
            if (wr & sel_ctrl) {irq_en, rx_en} <= bus_wdata[1:0];
            if (baud_wr) baudrate_reg <= bus_wdata[13:0];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(accept) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_sel = 1'b0, bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [13:0] baudrate_reg;
    logic        rx_reset, irq;
    logic [31:0] rdv;
    int          checks = 0, failures = 0;

    uart_rx_ctrl dut (
        .clk(clk), .reset(reset), .bus_sel(bus_sel), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .rx_done(rx_done), .rx_data(rx_data),
        .baudrate_reg(baudrate_reg), .rx_reset(rx_reset), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [3:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        step();
        bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0;
        chk("ready", {31'd0, bus_ready}, 32'd1);
        rd = bus_rdata;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b; rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_baud", {18'd0, baudrate_reg}, 32'h2580);
        chk("rst_rxreset", {31'd0, rx_reset}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        access(1'b0, 4'hC, 0, rdv); chk("rd_baud", rdv, 32'h2580);
        access(1'b0, 4'h4, 0, rdv); chk("rd_stat0", rdv, 32'h0);
        access(1'b0, 4'h1, 0, rdv); chk("rd_undec", rdv, 32'h0);
        step();
        chk("idle_ready", {31'd0, bus_ready}, 32'd0);
        chk("idle_rdata", bus_rdata, 32'd0);
        access(1'b1, 4'h8, 32'h3, rdv);
        chk("en_rxreset", {31'd0, rx_reset}, 32'd0);
        chk("en_irq", {31'd0, irq}, 32'd0);

        // one long rx_done pulse must produce exactly one byte
        rx_data = 8'h41; rx_done = 1'b1;
        repeat (500) step();
        rx_done = 1'b0;
        access(1'b0, 4'h4, 0, rdv); chk("long_stat", rdv, 32'h11);
        chk("long_irq", {31'd0, irq}, 32'd1);
        access(1'b0, 4'h0, 0, rdv); chk("long_data", rdv, 32'h141);
        access(1'b0, 4'h4, 0, rdv); chk("long_stat2", rdv, 32'h0);
        chk("long_irq0", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        access(1'b0, 4'h4, 0, rdv); chk("full_stat", rdv, (32'd8 << 4) | 32'h4 | 32'h2 | 32'h1);
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 4'h0, 0, rdv); chk("drain", rdv, 32'h110 + 32'(i));
        end
        access(1'b0, 4'h0, 0, rdv); chk("empty_rd", rdv, 32'h0);
        access(1'b0, 4'h4, 0, rdv); chk("ovr_sticky", rdv, 32'h4);

        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
        rx_data = 8'h23; rx_done = 1'b1;
        access(1'b0, 4'h0, 0, rdv); chk("pp_data", rdv, 32'h120);
        rx_done = 1'b0;
        step();
        access(1'b0, 4'h4, 0, rdv); chk("pp_stat", rdv, 32'h35);
        access(1'b1, 4'h4, 32'h4, rdv);
        access(1'b0, 4'h4, 0, rdv); chk("ovr_clr", rdv, 32'h31);
        for (int i = 1; i < 4; i++) begin
            access(1'b0, 4'h0, 0, rdv); chk("pp_drain", rdv, 32'h120 + 32'(i));
        end

        access(1'b1, 4'hC, 32'h0, rdv);
        chk("baud0", {18'd0, baudrate_reg}, 32'h2580);
        chk("baud0_rxreset", {31'd0, rx_reset}, 32'd0);
        access(1'b1, 4'hC, 32'h1C00, rdv);
        chk("baud_new", {18'd0, baudrate_reg}, 32'h1C00);
        chk("baud_hold1", {31'd0, rx_reset}, 32'd1);
        step(); chk("baud_hold2", {31'd0, rx_reset}, 32'd1);
        step(); chk("baud_hold3", {31'd0, rx_reset}, 32'd0);
        access(1'b0, 4'hC, 0, rdv); chk("rd_baud2", rdv, 32'h1C00);

        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        access(1'b0, 4'h4, 0, rdv); chk("five_stat", rdv, 32'h51);
        chk("five_irq", {31'd0, irq}, 32'd1);
        rx_data = 8'h55; rx_done = 1'b1;
        access(1'b1, 4'h8, 32'h7, rdv);
        chk("flush_irq_lag", {31'd0, irq}, 32'd1);
        rx_done = 1'b0;
        step();
        chk("flush_irq", {31'd0, irq}, 32'd0);
        access(1'b0, 4'h4, 0, rdv); chk("flush_stat", rdv, 32'h0);
        access(1'b0, 4'h8, 0, rdv); chk("rd_ctrl", rdv, 32'h3);

        for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
        rx_done = 1'b1; reset = 1'b1;
        bus_sel = 1'b1; bus_addr = 4'h0;
        step();
        reset = 1'b0; rx_done = 1'b0; bus_sel = 1'b0;
        chk("mid_baud", {18'd0, baudrate_reg}, 32'h2580);
        chk("mid_rxreset", {31'd0, rx_reset}, 32'd1);
        chk("mid_irq", {31'd0, irq}, 32'd0);
        chk("mid_ready", {31'd0, bus_ready}, 32'd0);
        chk("mid_rdata", bus_rdata, 32'd0);
        access(1'b0, 4'h4, 0, rdv); chk("mid_stat", rdv, 32'h0);
        access(1'b0, 4'h8, 0, rdv); chk("mid_ctrl", rdv, 32'h0);
        access(1'b0, 4'h0, 0, rdv); chk("mid_data", rdv, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
